// File: rtl/proc_core_mc.sv
// Multi-cycle 4-op-class processor core: FETCH -> EXEC (-> MEM) -> FETCH, with
// separate instruction/data request-acknowledge interfaces and a 16x DATA_W register file.
module proc_core_mc #(
  parameter int DATA_W = 32,
  parameter int PC_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [PC_W-1:0]   pc,
  output logic [2:0]        flags,
  output logic              halted
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [2:0]        flags_q, flags_d;
  logic [31:0]       ir_q, ir_d;
  logic [DATA_W-1:0] rf_q [16];

  logic              rf_we;
  logic [3:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;

  logic [1:0]        op, arg;
  logic [3:0]        fa, fb, fc, fd;
  logic [DATA_W-1:0] imm, rd_fa, rd_fb, rd_fc, rd_fd;

  assign op    = ir_q[31:30];
  assign arg   = ir_q[29:28];
  assign fa    = ir_q[27:24];
  assign fb    = ir_q[19:16];
  assign fc    = ir_q[11:8];
  assign fd    = ir_q[3:0];
  assign imm   = DATA_W'(ir_q[23:0]);
  assign rd_fa = rf_q[fa];
  assign rd_fb = rf_q[fb];
  assign rd_fc = rf_q[fc];
  assign rd_fd = rf_q[fd];

  // One extra MSB on every ALU path captures carry / not-borrow / shifted-out bit.
  logic [DATA_W:0]   add_full, sub_full, shl_full;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c;

  assign add_full = {1'b0, rd_fc} + {1'b0, rd_fd};
  assign sub_full = {1'b0, rd_fc} + {1'b0, ~rd_fd} + {{DATA_W{1'b0}}, 1'b1};
  assign shl_full = {1'b0, rd_fc} << fa;

  always_comb begin
    alu_res = add_full[DATA_W-1:0];
    alu_c   = add_full[DATA_W];
    case (arg)
      2'b01: begin alu_res = sub_full[DATA_W-1:0]; alu_c = sub_full[DATA_W]; end
      2'b10: begin alu_res = rd_fc & rd_fd;        alu_c = 1'b0;             end
      2'b11: begin alu_res = shl_full[DATA_W-1:0]; alu_c = shl_full[DATA_W]; end
      default: ;
    endcase
  end

  logic              jmp_take;
  logic [DATA_W-1:0] jmp_full;
  logic [PC_W-1:0]   jmp_tgt, pc_inc;

  // flags_q is {C,N,Z}; jumps never write flags, so this sees pre-jump flags.
  always_comb begin
    case (arg)
      2'b00:   jmp_take = 1'b1;
      2'b01:   jmp_take = flags_q[0];
      2'b10:   jmp_take = ~flags_q[0];
      default: jmp_take = flags_q[1];
    endcase
  end

  assign jmp_full = ir_q[24] ? imm : rd_fb;
  assign jmp_tgt  = PC_W'(jmp_full);
  assign pc_inc   = pc_q + PC_W'(1);

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    flags_d  = flags_q;
    ir_d     = ir_q;
    rf_we    = 1'b0;
    rf_waddr = fa;
    rf_wdata = imm;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_FETCH;
        pc_d    = pc_inc;
        case (op)
          2'b00: if (arg == 2'b11) begin
            state_d = S_HALT;
            pc_d    = pc_q;
          end
          2'b01: begin
            case (arg)
              2'b01: begin rf_we = 1'b1; rf_wdata = imm;   end
              2'b11: begin rf_we = 1'b1; rf_wdata = rd_fb; end
              default: begin
                state_d = S_MEM;
                pc_d    = pc_q;
              end
            endcase
          end
          2'b10: if (jmp_take) pc_d = jmp_tgt;
          default: begin
            rf_we    = 1'b1;
            rf_waddr = fb;
            rf_wdata = alu_res;
            flags_d  = {alu_c, alu_res[DATA_W-1], (alu_res == '0)};
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = arg[1];
        if (dmem_ack) begin
          rf_we    = ~arg[1];
          rf_wdata = dmem_rdata;
          pc_d     = pc_inc;
          state_d  = S_FETCH;
        end
      end
      default: ;
    endcase
  end

  // Address/data come straight from the register file, which is frozen while in MEM.
  assign dmem_addr  = arg[1] ? rd_fa : rd_fb;
  assign dmem_wdata = rd_fb;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign flags      = flags_q;
  assign halted     = (state_q == S_HALT);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      flags_q <= 3'b000;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      ir_q    <= ir_d;
    end
  end

  // Register file is not cleared; the reset gate blocks writes from an interrupted instruction.
  always_ff @(posedge clk) begin
    if (reset && rf_we) rf_q[rf_waddr] <= rf_wdata;
  end

endmodule

// File: tb/tb_proc_core_mc.sv
// Directed self-checking bench for proc_core_mc: small programs in a behavioural
// instruction ROM and a data RAM with programmable ack delay.
module tb_proc_core_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req, imem_ack;
  logic [15:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [15:0] pc;
  logic [2:0]  flags;
  logic        halted;

  logic [31:0] imem [0:65535];
  logic [31:0] dmem [0:255];
  int          dmem_delay = 0;
  logic        ack_spray  = 1'b0;
  int          dcnt       = 0;
  int          wr_cnt     = 0;
  int          st_cycles  = 0;
  int          stab_err   = 0;
  logic [31:0] lat_addr, lat_wdata;
  logic        lat_we;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  proc_core_mc #(.DATA_W(32), .PC_W(16)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .pc(pc), .flags(flags), .halted(halted)
  );

  assign imem_rdata = imem[imem_addr];
  assign imem_ack   = imem_req | ack_spray;
  assign dmem_rdata = dmem[dmem_addr[7:0]];
  assign dmem_ack   = (dmem_req && (dcnt == dmem_delay)) | ack_spray;

  always @(posedge clk) begin
    if (dmem_req && !dmem_ack) dcnt <= dcnt + 1;
    else                       dcnt <= 0;
    if (dmem_req) begin
      if (dcnt == 0) begin
        lat_addr  <= dmem_addr;
        lat_wdata <= dmem_wdata;
        lat_we    <= dmem_we;
      end else if (dmem_addr !== lat_addr || dmem_wdata !== lat_wdata || dmem_we !== lat_we) begin
        stab_err <= stab_err + 1;
      end
      if (dmem_we) st_cycles <= st_cycles + 1;
      if (dmem_ack && dmem_we) begin
        dmem[dmem_addr[7:0]] <= dmem_wdata;
        wr_cnt <= wr_cnt + 1;
      end
    end
  end

  function automatic logic [31:0] f_loadi(input logic [3:0] a, input logic [23:0] v);
    return {2'b01, 2'b01, a, v};
  endfunction
  function automatic logic [31:0] f_mem(input logic [1:0] ar, input logic [3:0] a, input logic [3:0] b);
    return {2'b01, ar, a, 4'h0, b, 16'h0};
  endfunction
  function automatic logic [31:0] f_alu(input logic [1:0] ar, input logic [3:0] sh, input logic [3:0] b,
                                        input logic [3:0] c, input logic [3:0] d);
    return {2'b11, ar, sh, 4'h0, b, 4'h0, c, 4'h0, d};
  endfunction
  function automatic logic [31:0] f_jimm(input logic [1:0] cond, input logic [23:0] t);
    return {2'b10, cond, 4'h1, t};
  endfunction
  function automatic logic [31:0] f_jreg(input logic [1:0] cond, input logic [3:0] b);
    return {2'b10, cond, 4'h0, 4'h0, b, 16'h0};
  endfunction
  localparam logic [31:0] HALT_I = 32'h3000_0000;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick(1);
    reset = 1'b1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 65536; i++) imem[i] = 32'h0;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic wait_halt(input int max_cycles);
    for (int i = 0; i < max_cycles && halted !== 1'b1; i++) tick(1);
    check("halt_reached", {63'h0, halted}, 64'h1);
  endtask

  int req_seen;
  int wr0, st0, se0;

  initial begin
    reset = 1'b0;

    // S1: LOADI/LOADI/SUB latency and flags, HALT, reset out of HALT
    clear_imem();
    imem[0] = f_loadi(4'd1, 24'd5);
    imem[1] = f_loadi(4'd2, 24'd5);
    imem[2] = f_alu(2'b01, 4'd0, 4'd3, 4'd1, 4'd2);
    imem[3] = HALT_I;
    do_reset();
    check("rst_pc", pc, 0);
    check("rst_flags", flags, 0);
    check("rst_halted", halted, 0);
    check("rst_imem_req", imem_req, 1);
    check("rst_dmem_req", dmem_req, 0);
    tick(5);
    check("s1_pc_at5", pc, 2);
    tick(1);
    check("s1_pc_at6", pc, 3);
    check("s1_r3", dut.rf_q[3], 0);
    check("s1_flags_CNZ", flags, 3'b101);
    tick(2);
    check("s1_halted", halted, 1);
    check("s1_halt_pc", pc, 3);
    ack_spray = 1'b1;
    req_seen  = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (imem_req !== 1'b0 || dmem_req !== 1'b0) req_seen++;
    end
    ack_spray = 1'b0;
    check("halt_req_cycles", req_seen, 0);
    check("halt_stays", {halted, pc}, {1'b1, 16'd3});
    do_reset();
    check("halt_rst_pc", pc, 0);
    check("halt_rst_halted", halted, 0);
    check("halt_rst_imem_req", imem_req, 1);
    check("rf_kept_r1", dut.rf_q[1], 5);
    $display("S1 done pc=%0h flags=%0b", pc, flags);

    // S2: ALU ops and flags (spurious acks in non-handshake cycles must be ignored)
    clear_imem();
    imem[0] = f_loadi(4'd0, 24'd0);
    imem[1] = f_loadi(4'd2, 24'd1);
    imem[2] = f_alu(2'b01, 4'd0, 4'd1, 4'd0, 4'd2);
    imem[3] = f_alu(2'b00, 4'd0, 4'd4, 4'd1, 4'd1);
    imem[4] = f_alu(2'b11, 4'd15, 4'd5, 4'd2, 4'd0);
    imem[5] = f_alu(2'b10, 4'd0, 4'd6, 4'd1, 4'd0);
    imem[6] = HALT_I;
    do_reset();
    ack_spray = 1'b1;
    tick(6);
    check("sub_r1", dut.rf_q[1], 32'hFFFF_FFFF);
    check("sub_flags", flags, 3'b010);
    tick(2);
    check("add_r4", dut.rf_q[4], 32'hFFFF_FFFE);
    check("add_flags", flags, 3'b110);
    tick(2);
    check("shl_r5", dut.rf_q[5], 32'h0000_8000);
    check("shl_flags", flags, 3'b000);
    tick(2);
    check("and_r6", dut.rf_q[6], 0);
    check("and_flags", flags, 3'b001);
    ack_spray = 1'b0;
    wait_halt(20);
    $display("S2 done r4=%0h flags=%0b", dut.rf_q[4], flags);

    // S3: STORE with 3 wait cycles, then LOAD back
    clear_imem();
    imem[0] = f_loadi(4'd5, 24'h10);
    imem[1] = f_loadi(4'd6, 24'hAB);
    imem[2] = f_mem(2'b10, 4'd5, 4'd6);
    imem[3] = f_loadi(4'd7, 24'd0);
    imem[4] = f_mem(2'b00, 4'd7, 4'd5);
    imem[5] = HALT_I;
    dmem_delay = 3;
    do_reset();
    wr0 = wr_cnt; st0 = st_cycles; se0 = stab_err;
    tick(9);
    check("st_pc_wait", pc, 2);
    check("st_req_we", {dmem_req, dmem_we}, 2'b11);
    check("st_addr", dmem_addr, 32'h10);
    check("st_wdata", dmem_wdata, 32'hAB);
    tick(1);
    check("st_pc_done", pc, 3);
    wait_halt(100);
    check("st_writes", wr_cnt - wr0, 1);
    check("st_req_cycles", st_cycles - st0, 4);
    check("st_stable", stab_err - se0, 0);
    check("st_mem", dmem[8'h10], 32'hAB);
    check("ld_r7", dut.rf_q[7], 32'hAB);
    check("mem_pc", pc, 5);
    $display("S3 done r7=%0h writes=%0d", dut.rf_q[7], wr_cnt - wr0);

    // S4: conditional and register jumps
    clear_imem();
    imem[0]     = f_loadi(4'd1, 24'd1);
    imem[1]     = f_loadi(4'd2, 24'd0);
    imem[2]     = f_alu(2'b00, 4'd0, 4'd3, 4'd1, 4'd2);
    imem[3]     = f_jimm(2'b01, 24'h40);
    imem[4]     = f_jimm(2'b10, 24'h40);
    imem[16'h40] = f_loadi(4'd9, 24'h80);
    imem[16'h41] = f_jreg(2'b00, 4'd9);
    imem[16'h80] = HALT_I;
    dmem_delay = 0;
    do_reset();
    tick(6);
    check("j_pre_flags", flags, 3'b000);
    tick(2);
    check("jz_not_taken", pc, 4);
    tick(2);
    check("jnz_taken", pc, 16'h40);
    tick(4);
    check("jreg_taken", pc, 16'h80);
    wait_halt(10);
    $display("S4 done pc=%0h", pc);

    // S5: pc wraps from 0xFFFF
    clear_imem();
    imem[0] = f_jimm(2'b00, 24'h00FFFF);
    do_reset();
    tick(2);
    check("pc_max", pc, 16'hFFFF);
    tick(2);
    check("pc_wrap", pc, 0);
    $display("S5 done pc=%0h", pc);

    // S6: reset during an outstanding store
    clear_imem();
    imem[0] = f_loadi(4'd5, 24'h20);
    imem[1] = f_loadi(4'd6, 24'h55);
    imem[2] = f_mem(2'b10, 4'd5, 4'd6);
    dmem_delay = 5;
    do_reset();
    wr0 = wr_cnt;
    tick(7);
    check("mid_dmem_req", dmem_req, 1);
    do_reset();
    check("mid_rst_dmem_req", dmem_req, 0);
    check("mid_rst_imem_req", imem_req, 1);
    check("mid_rst_pc", pc, 0);
    tick(1);
    check("mid_rst_no_write", wr_cnt - wr0, 0);
    $display("S6 done writes=%0d", wr_cnt - wr0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/proc_core_mc.md
PROC_CORE_MC -- requirements
Module: proc_core_mc

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, setting datapath and register width; legal values are 24 and above.
REQ-002 The block SHALL have parameter PC_W, default 16, setting program-counter and instruction-address width.
REQ-003 The block SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  in  1  synchronous, active-low reset.
REQ-005 The block SHALL have ports imem_req out 1, imem_addr out PC_W, imem_rdata in 32, imem_ack in 1, forming the instruction-fetch handshake.
REQ-006 The block SHALL have ports dmem_req out 1, dmem_we out 1, dmem_addr out DATA_W, dmem_wdata out DATA_W, dmem_rdata in DATA_W, dmem_ack in 1, forming the data-memory handshake.
REQ-007 The block SHALL have ports pc out PC_W, flags out 3 ({C,N,Z}) and halted out 1, as status outputs.

Function
REQ-008 The block SHALL decode IR as follows: op=IR[31:30]; arg=IR[29:28]; fa=IR[27:24]; fb=IR[19:16]; fc=IR[11:8]; fd=IR[3:0]; imm=IR[23:0] zero-extended to DATA_W.
REQ-009 The block SHALL use a 16-entry register file of DATA_W bits, with no hardwired-zero register.
REQ-010 The block SHALL implement states FETCH, EXEC, MEM and HALT, and SHALL enter FETCH from reset.
REQ-011 In FETCH, the block SHALL drive imem_req=1 and imem_addr=pc; on imem_ack it SHALL latch imem_rdata into IR and go to EXEC; without ack it SHALL hold.
REQ-012 For op=00, the block SHALL treat arg 00/01/10 as NOP and arg=11 as HALT, which enters state HALT without advancing pc.
REQ-013 For op=01, the block SHALL decode arg as: 00 LOAD R[fa]<=mem[R[fb]]; 01 LOADI R[fa]<=imm; 10 STORE mem[R[fa]]<=R[fb]; 11 MOVE R[fa]<=R[fb].
REQ-014 For op=10, the block SHALL jump with target=imm if IR[24] else R[fb], conditioned on arg: 00 always, 01 Z=1, 10 Z=0, 11 N=1.
REQ-015 For op=11, the block SHALL perform ALU R[fb]<=f(R[fc],R[fd]) with arg: 00 ADD, 01 SUB, 10 AND, 11 R[fc] logical-shift-left by fa (0-15).
REQ-016 Each ALU operation SHALL set Z=(result==0), N=result[DATA_W-1] and C=carry-out (ADD), NOT borrow (SUB), 0 (AND) or last bit shifted out (SHL; 0 when shift is 0); non-ALU instructions SHALL leave flags unchanged.
REQ-017 A jump condition SHALL evaluate flags as they stood before the jump instruction.
REQ-018 In EXEC, a non-memory instruction SHALL commit its register write, flags and next pc, then go to FETCH; LOAD and STORE SHALL go to MEM.
REQ-019 In MEM, the block SHALL hold dmem_req=1 with dmem_addr, dmem_we and dmem_wdata stable until dmem_ack; on ack a LOAD SHALL write dmem_rdata to R[fa], pc SHALL advance, and the state SHALL become FETCH.
REQ-020 Next pc SHALL be (pc+1) mod 2^PC_W for a sequential or untaken step, or the target truncated to PC_W bits when a jump is taken.
REQ-021 Latency: a non-memory instruction SHALL take 2 cycles and a memory instruction 3 cycles with zero-wait acks; each wait cycle SHALL add one cycle.
REQ-022 In HALT, the block SHALL assert halted=1 and SHALL drive both req outputs to 0; only reset exits HALT.
REQ-023 The block SHALL ignore an ack that arrives while its corresponding req is low.
REQ-024 dmem_we SHALL be 1 only while in MEM during a STORE.

Reset
REQ-025 When reset=0 at a clk edge, the block SHALL set pc=0, flags=000, halted=0, IR=0 and state=FETCH.
REQ-026 Reset SHALL override any in-flight handshake; the block SHALL drop req in the cycle after the reset edge and SHALL NOT perform any partial write.
REQ-027 Register-file contents SHALL NOT be cleared by reset.

Verification
REQ-028 Scenario: LOADI R1,5; LOADI R2,5; SUB R3=R1-R2 -> R3=0, Z=1, C=1, N=0, pc=3 after 6 cycles with zero-wait acks.
REQ-029 Scenario: R1=0xFFFFFFFF, ADD R4=R1+R1 -> R4=0xFFFFFFFE, C=1, N=1, Z=0.
REQ-030 Scenario: STORE mem[R5=0x10]<=R6=0xAB with dmem_ack delayed 3 cycles -> req/addr/wdata held stable for 4 cycles, one write occurs, then LOAD R7 from 0x10 gives 0xAB.
REQ-031 Scenario: Z=0, conditional jump on Z=1 to imm 0x40 -> not taken, pc=prev+1; jump on Z=0 -> pc=0x40.
REQ-032 Scenario: pc=2^PC_W-1 executes NOP -> pc=0.
REQ-033 Scenario: HALT -> halted=1 and reqs stay 0 for 10 cycles; then reset=0 for one edge -> pc=0, state FETCH, imem_req=1.
